// File: rtl/fp_div_iter.sv
// fp_div_iter: iterative floating-point divider, radix-2 restoring, one quotient bit per cycle.
//
// Computes res = op_a / op_b in a parametrised IEEE-754-style format with round-to-nearest-even.
// One operation is in flight at a time. Operands are captured on the input handshake. The result
// and flags are held until the consumer takes them.
//
// Build option:
//   FP_DIV_IEEE_SPECIAL_EN - when defined, NaN/inf/zero operands are detected and short-cut, and
//                            the invalid / div_zero flags are live. When undefined, every operand
//                            is treated as a normal number with an implicit leading 1, and invalid /
//                            div_zero stay 0.
//
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   i_in_valid     operands valid
//   o_in_ready     divider idle, operands will be accepted
//   i_op_a         dividend
//   i_op_b         divisor
//   o_out_valid    result and flags valid
//   i_out_ready    consumer accepts the result
//   o_res          quotient a/b
//   o_overflow     result overflowed to infinity
//   o_underflow    result flushed to zero
//   o_invalid      0/0 or inf/inf
//   o_div_zero     finite nonzero value divided by zero
//   o_inexact      result is not exact

module fp_div_iter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_op_a,
  input  logic [DATA_W-1:0] i_op_b,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_res,
  output logic              o_overflow,
  output logic              o_underflow,
  output logic              o_invalid,
  output logic              o_div_zero,
  output logic              o_inexact
);

  localparam int unsigned FRAC_W = DATA_W - EXP_W - 1;
  localparam int unsigned BIAS   = 2**(EXP_W-1) - 1;
  // Quotient: 1 integer bit, FRAC_W fraction bits, guard, round.
  localparam int unsigned QW     = FRAC_W + 3;
  localparam int unsigned CW     = $clog2(FRAC_W + 4);
  // Working exponent is signed, two bits wider than the field.
  localparam int unsigned EW     = EXP_W + 2;

  localparam logic [EW-1:0] BIAS_X    = EW'(BIAS);
  localparam logic [EW-1:0] EMAX_X    = EW'(2**EXP_W - 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(QW - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UNPACK = 3'd1;
  localparam logic [2:0] S_DIVIDE = 3'd2;
  localparam logic [2:0] S_NORM   = 3'd3;
  localparam logic [2:0] S_OUT    = 3'd4;

  logic [2:0]        r_state;
  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_op_b;
  logic              r_sign;
  logic [EW-1:0]     r_exp;
  logic [FRAC_W:0]   r_mb;
  logic [FRAC_W+1:0] r_rem;
  logic [QW-1:0]     r_q;
  logic [CW-1:0]     r_cnt;
  logic              r_spec;
  logic [DATA_W-1:0] r_spec_res;
  logic              r_spec_inv;
  logic              r_spec_dz;
  logic [DATA_W-1:0] r_res;
  logic              r_overflow;
  logic              r_underflow;
  logic              r_invalid;
  logic              r_div_zero;
  logic              r_inexact;

  // ---------------------------------------------------------------------------------------------
  // Unpack
  // ---------------------------------------------------------------------------------------------
  logic              w_sa;
  logic              w_sb;
  logic [EXP_W-1:0]  w_ea;
  logic [EXP_W-1:0]  w_eb;
  logic [FRAC_W-1:0] w_fa;
  logic [FRAC_W-1:0] w_fb;
  logic              w_sign_u;
  logic [EW-1:0]     w_exp_u;
  logic [FRAC_W:0]   w_ma;
  logic [FRAC_W:0]   w_mb;

  assign w_sa     = r_op_a[DATA_W-1];
  assign w_sb     = r_op_b[DATA_W-1];
  assign w_ea     = r_op_a[DATA_W-2 -: EXP_W];
  assign w_eb     = r_op_b[DATA_W-2 -: EXP_W];
  assign w_fa     = r_op_a[FRAC_W-1:0];
  assign w_fb     = r_op_b[FRAC_W-1:0];
  assign w_sign_u = w_sa ^ w_sb;
  assign w_exp_u  = {2'b00, w_ea} - {2'b00, w_eb} + BIAS_X;
  assign w_ma     = {1'b1, w_fa};
  assign w_mb     = {1'b1, w_fb};

  logic              w_spec;
  logic [DATA_W-1:0] w_spec_res;
  logic              w_spec_inv;
  logic              w_spec_dz;

`ifdef FP_DIV_IEEE_SPECIAL_EN
  logic              w_a_zero;
  logic              w_b_zero;
  logic              w_a_inf;
  logic              w_b_inf;
  logic              w_a_nan;
  logic              w_b_nan;
  logic [DATA_W-1:0] w_qnan;
  logic [DATA_W-1:0] w_inf;
  logic [DATA_W-1:0] w_zero;

  // A zero exponent field means zero regardless of fraction: no subnormal support.
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_inf  = (&w_ea) && (w_fa == '0);
  assign w_b_inf  = (&w_eb) && (w_fb == '0);
  assign w_a_nan  = (&w_ea) && (w_fa != '0);
  assign w_b_nan  = (&w_eb) && (w_fb != '0);
  assign w_qnan   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
  assign w_inf    = {w_sign_u, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
  assign w_zero   = {w_sign_u, {(DATA_W-1){1'b0}}};

  // Priority chain: NaN, invalid, inf/x, x/0, 0/x or x/inf.
  always_comb begin
    w_spec     = 1'b1;
    w_spec_res = '0;
    w_spec_inv = 1'b0;
    w_spec_dz  = 1'b0;
    if (w_a_nan || w_b_nan) begin
      w_spec_res = w_qnan;
    end else if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_spec_res = w_qnan;
      w_spec_inv = 1'b1;
    end else if (w_a_inf) begin
      w_spec_res = w_inf;
    end else if (w_b_zero) begin
      w_spec_res = w_inf;
      w_spec_dz  = 1'b1;
    end else if (w_a_zero || w_b_inf) begin
      w_spec_res = w_zero;
    end else begin
      w_spec     = 1'b0;
    end
  end
`else
  assign w_spec     = 1'b0;
  assign w_spec_res = '0;
  assign w_spec_inv = 1'b0;
  assign w_spec_dz  = 1'b0;
`endif

  // ---------------------------------------------------------------------------------------------
  // Restoring divide step
  // ---------------------------------------------------------------------------------------------
  // The partial remainder is always below 2*divisor, so FRAC_W+2 bits hold it.
  logic [QW-1:0]     w_diff;
  logic              w_ge;
  logic [FRAC_W+1:0] w_rem_sub;
  logic [FRAC_W+1:0] w_rem_nx;

  assign w_diff    = {1'b0, r_rem} - {2'b00, r_mb};
  assign w_ge      = ~w_diff[QW-1];
  assign w_rem_sub = w_diff[QW-2:0];
  assign w_rem_nx  = w_ge ? (w_rem_sub << 1) : (r_rem << 1);

  // ---------------------------------------------------------------------------------------------
  // Normalise, round to nearest even, classify
  // ---------------------------------------------------------------------------------------------
  logic [QW-1:0]     w_norm_q;
  logic [EW-1:0]     w_norm_e;
  logic [FRAC_W:0]   w_mant;
  logic              w_guard;
  logic              w_round;
  logic              w_sticky;
  logic              w_up;
  logic [FRAC_W+1:0] w_mant_rnd;
  logic              w_carry;
  logic [FRAC_W-1:0] w_frac;
  logic [EW-1:0]     w_fin_e;
  logic              w_ovf;
  logic              w_unf;
  logic              w_inexact;
  logic [DATA_W-1:0] w_res;

  assign w_norm_q   = r_q[QW-1] ? r_q : {r_q[QW-2:0], 1'b0};
  assign w_norm_e   = r_q[QW-1] ? r_exp : (r_exp - EW'(1));
  assign w_mant     = w_norm_q[QW-1:2];
  assign w_guard    = w_norm_q[1];
  assign w_round    = w_norm_q[0];
  assign w_sticky   = (r_rem != '0);
  assign w_up       = w_guard & (w_round | w_sticky | w_mant[0]);
  assign w_mant_rnd = {1'b0, w_mant} + {{(FRAC_W+1){1'b0}}, w_up};
  // A rounding carry only happens from an all-ones mantissa, leaving 1.000...
  assign w_carry    = w_mant_rnd[FRAC_W+1];
  assign w_frac     = w_carry ? w_mant_rnd[FRAC_W:1] : w_mant_rnd[FRAC_W-1:0];
  assign w_fin_e    = w_carry ? (w_norm_e + EW'(1)) : w_norm_e;
  assign w_ovf      = !w_fin_e[EW-1] && (w_fin_e >= EMAX_X);
  assign w_unf      = w_fin_e[EW-1] || (w_fin_e == '0);
  assign w_inexact  = w_guard | w_round | w_sticky;

  always_comb begin
    w_res = {r_sign, w_fin_e[EXP_W-1:0], w_frac};
    if (w_ovf) begin
      w_res = {r_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (w_unf) begin
      w_res = {r_sign, {(DATA_W-1){1'b0}}};
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Control and state
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_mb        <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      r_spec      <= 1'b0;
      r_spec_res  <= '0;
      r_spec_inv  <= 1'b0;
      r_spec_dz   <= 1'b0;
      r_res       <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_invalid   <= 1'b0;
      r_div_zero  <= 1'b0;
      r_inexact   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_op_a  <= i_op_a;
            r_op_b  <= i_op_b;
            r_state <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          r_sign     <= w_sign_u;
          r_exp      <= w_exp_u;
          r_mb       <= w_mb;
          r_rem      <= {1'b0, w_ma};
          r_q        <= '0;
          r_cnt      <= '0;
          r_spec     <= w_spec;
          r_spec_res <= w_spec_res;
          r_spec_inv <= w_spec_inv;
          r_spec_dz  <= w_spec_dz;
          // Specials skip the divider and take the NORM slot, so their result appears two
          // cycles after the input handshake.
          r_state    <= w_spec ? S_NORM : S_DIVIDE;
        end
        S_DIVIDE: begin
          r_rem <= w_rem_nx;
          r_q   <= {r_q[QW-2:0], w_ge};
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST_STEP) begin
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          if (r_spec) begin
            r_res       <= r_spec_res;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_invalid   <= r_spec_inv;
            r_div_zero  <= r_spec_dz;
            r_inexact   <= 1'b0;
          end else begin
            r_res       <= w_res;
            r_overflow  <= w_ovf;
            r_underflow <= w_unf;
            r_invalid   <= 1'b0;
            r_div_zero  <= 1'b0;
            r_inexact   <= w_inexact | w_ovf | w_unf;
          end
          r_state <= S_OUT;
        end
        S_OUT: begin
          if (i_out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready  = (r_state == S_IDLE);
  assign o_out_valid = (r_state == S_OUT);
  assign o_res       = r_res;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;
  assign o_invalid   = r_invalid;
  assign o_div_zero  = r_div_zero;
  assign o_inexact   = r_inexact;

endmodule
